// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared constants, baud divisor table and frame builder
// for the UART transmit datapath.
package uart_tx_pkg;

    localparam int FRAME_BITS   = 11;
    localparam int BAUD_ENTRIES = 12;
    localparam int BAUD_MAX_IDX = BAUD_ENTRIES - 1;

    // Clock divisors for a 100 MHz clk, indexed by baud_sel.
    localparam int unsigned BAUD_DIV [BAUD_ENTRIES] = '{
        333333, 83333, 41667, 20833, 10417, 5208,
        2604,   1736,  868,   434,   217,   109
    };

    // Frame layout on the wire, LSB first: start, data[6:0], b8, b9, stop.
    function automatic logic [FRAME_BITS-1:0] frame_bits(
        input logic [7:0] ldata,
        input logic       eight,
        input logic       pen,
        input logic       ohel
    );
        logic par;
        logic b8;
        logic b9;
        par = (eight ? ^ldata : ^ldata[6:0]) ^ ohel;
        if (eight) begin
            b8 = ldata[7];
            b9 = pen ? par : 1'b1;
        end else begin
            b8 = pen ? par : 1'b1;
            b9 = 1'b1;
        end
        return {1'b1, b9, b8, ldata[6:0], 1'b0};
    endfunction

endpackage

// File: rtl/bit_time_counter.sv
// bit_time_counter: counts clocks while a frame is active and emits a
// one-cycle BTU pulse every div clocks.
module bit_time_counter #(
    parameter int CNT_W = 19
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             DOIT,
    input  logic [CNT_W-1:0] div,
    output logic             BTU
);

    logic [CNT_W-1:0] count;

    // Gated by DOIT so BTU stays low while idle even for a divisor of 1.
    assign BTU = DOIT && (count == (div - CNT_W'(1)));

    // Free-run while the frame is active; wrap on each bit time.
    always_ff @(posedge clk) begin
        if (reset || !DOIT || BTU) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/tx_shift_engine.sv
// tx_shift_engine: accepts a CPU byte, builds an 11-bit UART frame and
// shifts it out on TX, one bit per BTU. DOIT/BTU drive the external bit
// counter whose DONE ends the frame.
// Optional: define UART_TX_BREAK_EN to add the brk input that forces TX low.
module tx_shift_engine
    import uart_tx_pkg::*;
#(
    parameter int unsigned DIV_OVERRIDE = 0,
    parameter int          CNT_W        = 19
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] out_port,
    input  logic [3:0] baud_sel,
    input  logic       eight,
    input  logic       pen,
    input  logic       ohel,
    input  logic       DONE,
`ifdef UART_TX_BREAK_EN
    input  logic       brk,
`endif
    output logic       DOIT,
    output logic       BTU,
    output logic       TX,
    output logic       TXRDY
);

    logic [7:0]            ldata;
    logic                  load_d1;
    logic [FRAME_BITS-1:0] shift;
    logic [3:0]            baud_idx;
    logic [CNT_W-1:0]      div;

    // Divisor select; indices past the table end reuse the last entry.
    always_comb begin
        baud_idx = (baud_sel > 4'(BAUD_MAX_IDX)) ? 4'(BAUD_MAX_IDX) : baud_sel;
        if (DIV_OVERRIDE != 0) begin
            div = CNT_W'(DIV_OVERRIDE);
        end else begin
            div = CNT_W'(BAUD_DIV[baud_idx]);
        end
    end

    bit_time_counter #(
        .CNT_W (CNT_W)
    ) u_bit_time_counter (
        .clk   (clk),
        .reset (reset),
        .DOIT  (DOIT),
        .div   (div),
        .BTU   (BTU)
    );

    // Accept, frame build, shift and completion handshake.
    // DONE is qualified by DOIT so a DONE that lingers after the frame
    // cannot re-raise TXRDY over a fresh accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            ldata   <= 8'h00;
            load_d1 <= 1'b0;
            TXRDY   <= 1'b1;
            DOIT    <= 1'b0;
            shift   <= '1;
        end else begin
            load_d1 <= 1'b0;
            if (load && TXRDY) begin
                ldata   <= out_port;
                load_d1 <= 1'b1;
                TXRDY   <= 1'b0;
            end
            if (load_d1) begin
                shift <= frame_bits(ldata, eight, pen, ohel);
                DOIT  <= 1'b1;
            end else if (BTU) begin
                shift <= {1'b1, shift[FRAME_BITS-1:1]};
            end
            if (DONE && DOIT) begin
                DOIT  <= 1'b0;
                TXRDY <= 1'b1;
            end
        end
    end

    // Registered serial output; idles high from the 1-filled shifter.
    always_ff @(posedge clk) begin
        if (reset) begin
            TX <= 1'b1;
        end else begin
`ifdef UART_TX_BREAK_EN
            TX <= brk ? 1'b0 : shift[0];
`else
            TX <= shift[0];
`endif
        end
    end

endmodule

// File: tb/tb_tx_shift_engine.sv
// tb_tx_shift_engine: directed self-checking bench. dut0 uses a divisor
// of 4 for frame checks, dut1 uses the baud table for period checks.
// Each DUT gets a small model of the external 11-count bit counter.
module tb_tx_shift_engine;

    logic       clk = 1'b0;
    logic       rst0, rst1, load0, load1;
    logic       eight, pen, ohel, brk;
    logic [7:0] out_port;
    logic [3:0] baud_sel0, baud_sel1;
    logic       done0, done1;
    logic       doit0, btu0, tx0, txrdy0;
    logic       doit1, btu1, tx1, txrdy1;
    int         bc0, bc1;
    int         n_pass  = 0;
    int         n_total = 0;

    always #5 clk = ~clk;

    tx_shift_engine #(.DIV_OVERRIDE(4), .CNT_W(19)) dut0 (
        .clk(clk), .reset(rst0), .load(load0), .out_port(out_port),
        .baud_sel(baud_sel0), .eight(eight), .pen(pen), .ohel(ohel),
        .DONE(done0),
`ifdef UART_TX_BREAK_EN
        .brk(brk),
`endif
        .DOIT(doit0), .BTU(btu0), .TX(tx0), .TXRDY(txrdy0)
    );

    tx_shift_engine #(.DIV_OVERRIDE(0), .CNT_W(19)) dut1 (
        .clk(clk), .reset(rst1), .load(load1), .out_port(out_port),
        .baud_sel(baud_sel1), .eight(eight), .pen(pen), .ohel(ohel),
        .DONE(done1),
`ifdef UART_TX_BREAK_EN
        .brk(brk),
`endif
        .DOIT(doit1), .BTU(btu1), .TX(tx1), .TXRDY(txrdy1)
    );

    // External bit counter models: count BTUs during a frame, DONE at 11.
    always @(posedge clk) begin
        if (rst0 || !doit0) bc0 <= 0;
        else if (btu0)      bc0 <= bc0 + 1;
        if (rst1 || !doit1) bc1 <= 0;
        else if (btu1)      bc1 <= bc1 + 1;
    end
    assign done0 = (bc0 == 11);
    assign done1 = (bc1 == 11);

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_load(input logic [7:0] data, input logic e, input logic p, input logic o);
        @(negedge clk);
        eight    = e;
        pen      = p;
        ohel     = o;
        out_port = data;
        load0    = 1'b1;
        @(negedge clk);
        load0    = 1'b0;
    endtask

    // Observation only: call at the negedge just after the accept edge.
    task automatic capture_frame(
        input  int          inject_at,
        input  logic [7:0]  inject_data,
        output logic [10:0] bits,
        output logic        stable,
        output logic        doit_start,
        output int          btus,
        output logic        spacing_ok,
        output int          rdy_cycle,
        output logic        doit_late
    );
        logic [43:0] s;
        int          last_btu;
        s = '1; bits = '0; stable = 1'b1; btus = 0; spacing_ok = 1'b1;
        last_btu = -1; rdy_cycle = -1; doit_late = 1'b0;
        @(negedge clk);
        doit_start = doit0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (n < 44) s[n] = tx0;
            if (btu0) begin
                if (last_btu >= 0 && (n - last_btu) != 4) spacing_ok = 1'b0;
                last_btu = n;
                btus++;
            end
            if (rdy_cycle < 0 && txrdy0) rdy_cycle = n;
            if (n >= 45 && doit0) doit_late = 1'b1;
            load0 = 1'b0;
            if (n == inject_at) begin
                out_port = inject_data;
                load0    = 1'b1;
            end
        end
        load0 = 1'b0;
        for (int k = 0; k < 11; k++) begin
            bits[k] = s[4*k];
            for (int j = 1; j < 4; j++)
                if (s[4*k+j] !== s[4*k]) stable = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst0 = 1'b1; rst1 = 1'b1; load0 = 1'b0; load1 = 1'b0; brk = 1'b0;
        eight = 1'b1; pen = 1'b0; ohel = 1'b0; out_port = 8'h00;
        baud_sel0 = 4'd0; baud_sel1 = 4'd8;
        repeat (3) @(negedge clk);
        rst0 = 1'b0; rst1 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_total++;
            if ({tx0, txrdy0, doit0, btu0} !== 4'b1100)
                $display("FAIL reset_idle cycle %0d: got TX/TXRDY/DOIT/BTU=%b want 1100", i, {tx0, txrdy0, doit0, btu0});
            else n_pass++;
        end
        n_total++;
        if ({tx1, txrdy1, doit1, btu1} !== 4'b1100)
            $display("FAIL reset_idle_dut1: got %b want 1100", {tx1, txrdy1, doit1, btu1});
        else n_pass++;
    endtask

    task automatic test_parity_frame();
        logic [10:0] bits; logic stable, ds, sp, dl; int btus, rdy;
        do_load(8'hA5, 1'b1, 1'b1, 1'b0);
        capture_frame(-1, 8'h00, bits, stable, ds, btus, sp, rdy, dl);
        n_total++; if (ds !== 1'b1) $display("FAIL a5_doit_rise: got %b want 1", ds); else n_pass++;
        n_total++; if (bits !== 11'b10101001010) $display("FAIL a5_bits: got %b want 10101001010", bits); else n_pass++;
        n_total++; if (stable !== 1'b1) $display("FAIL a5_bit_width: got %b want 1", stable); else n_pass++;
        n_total++; if (rdy != 44) $display("FAIL a5_txrdy_cycle: got %0d want 44", rdy); else n_pass++;
        n_total++; if (btus != 11) $display("FAIL a5_btu_count: got %0d want 11", btus); else n_pass++;
    endtask

    task automatic test_seven_bit_no_parity();
        logic [10:0] bits; logic stable, ds, sp, dl; int btus, rdy;
        do_load(8'hFF, 1'b0, 1'b0, 1'b0);
        capture_frame(-1, 8'h00, bits, stable, ds, btus, sp, rdy, dl);
        n_total++; if (bits !== 11'b11111111110) $display("FAIL ff7_bits: got %b want 11111111110", bits); else n_pass++;
        n_total++; if (btus != 11) $display("FAIL ff7_btu_count: got %0d want 11", btus); else n_pass++;
        n_total++; if (sp !== 1'b1) $display("FAIL ff7_btu_spacing: got %b want 1", sp); else n_pass++;
    endtask

    task automatic test_seven_bit_parity();
        logic [10:0] bits; logic stable, ds, sp, dl; int btus, rdy;
        do_load(8'hD5, 1'b0, 1'b1, 1'b0);
        capture_frame(-1, 8'h00, bits, stable, ds, btus, sp, rdy, dl);
        n_total++; if (bits !== 11'b11010101010) $display("FAIL d5_7p_bits: got %b want 11010101010", bits); else n_pass++;
    endtask

    task automatic test_busy_load();
        logic [10:0] bits; logic stable, ds, sp, dl; int btus, rdy;
        do_load(8'hA5, 1'b1, 1'b1, 1'b0);
        capture_frame(10, 8'h00, bits, stable, ds, btus, sp, rdy, dl);
        n_total++; if (bits !== 11'b10101001010) $display("FAIL busy_bits: got %b want 10101001010", bits); else n_pass++;
        n_total++; if (rdy != 44) $display("FAIL busy_txrdy_cycle: got %0d want 44", rdy); else n_pass++;
        n_total++; if (dl !== 1'b0) $display("FAIL busy_second_frame: got DOIT late=%b want 0", dl); else n_pass++;
    endtask

    task automatic test_load_at_done();
        logic [10:0] bits; logic stable, ds, sp, dl; int btus, rdy;
        do_load(8'hFF, 1'b0, 1'b0, 1'b0);
        capture_frame(43, 8'h3C, bits, stable, ds, btus, sp, rdy, dl);
        n_total++; if (dl !== 1'b0) $display("FAIL done_edge_load: got DOIT late=%b want 0", dl); else n_pass++;
        n_total++; if ({txrdy0, tx0} !== 2'b11) $display("FAIL done_edge_idle: got TXRDY/TX=%b want 11", {txrdy0, tx0}); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        logic [10:0] bits; logic stable, ds, sp, dl; int btus, rdy;
        do_load(8'hA5, 1'b1, 1'b1, 1'b0);
        repeat (23) @(negedge clk);
        n_total++; if (doit0 !== 1'b1) $display("FAIL midframe_active: got DOIT=%b want 1", doit0); else n_pass++;
        rst0 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0;
        n_total++;
        if ({tx0, doit0, txrdy0, btu0} !== 4'b1010)
            $display("FAIL midframe_reset: got TX/DOIT/TXRDY/BTU=%b want 1010", {tx0, doit0, txrdy0, btu0});
        else n_pass++;
        do_load(8'h3C, 1'b1, 1'b1, 1'b1);
        capture_frame(-1, 8'h00, bits, stable, ds, btus, sp, rdy, dl);
        n_total++; if (bits !== 11'b11001111000) $display("FAIL after_reset_bits: got %b want 11001111000", bits); else n_pass++;
        n_total++; if (rdy != 44) $display("FAIL after_reset_txrdy_cycle: got %0d want 44", rdy); else n_pass++;
    endtask

    task automatic measure_period(input logic [3:0] sel, output int period);
        int t;
        @(negedge clk); rst1 = 1'b1;
        @(negedge clk); rst1 = 1'b0; baud_sel1 = sel;
        @(negedge clk); out_port = 8'h5A; load1 = 1'b1;
        @(negedge clk); load1 = 1'b0;
        t = 0;
        while (!btu1 && t < 2000) begin @(negedge clk); t++; end
        t = 0;
        do begin @(negedge clk); t++; end while (!btu1 && t < 2000);
        period = t;
    endtask

    task automatic test_baud_table();
        int p;
        measure_period(4'd8, p);
        n_total++; if (p != 868) $display("FAIL baud8_period: got %0d want 868", p); else n_pass++;
        measure_period(4'd15, p);
        n_total++; if (p != 109) $display("FAIL baud15_period: got %0d want 109", p); else n_pass++;
        measure_period(4'd11, p);
        n_total++; if (p != 109) $display("FAIL baud11_period: got %0d want 109", p); else n_pass++;
        @(negedge clk); rst1 = 1'b1;
        @(negedge clk); rst1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_parity_frame();
        test_seven_bit_no_parity();
        test_seven_bit_parity();
        test_busy_load();
        test_load_at_done();
        test_reset_mid_frame();
        test_baud_table();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tx_shift_engine.md
Name: tx_shift_engine

Overview:
- Transmit datapath and control stage that feeds the UART TX bit counter.
- Accepts a parallel byte from the CPU write strobe and builds an 11-bit frame (start, data, parity/stop, stop).
- Generates the bit-time pulse BTU and the frame-active flag DOIT, which go to the bit counter.
- Consumes the counter's DONE to end the frame, then raises TXRDY.

Parameters:
- DIV_OVERRIDE, 0, nonzero replaces the baud-table divisor with this value (simulation speed-up); 0 = use the table.
- CNT_W, 19, width of the bit-time counter; must hold the largest divisor.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- load  in  1  one-cycle write strobe; accepted only when TXRDY=1.
- out_port  in  8  byte to transmit.
- baud_sel  in  4  baud index into the divisor table.
- eight  in  1  1 = 8 data bits, 0 = 7 data bits.
- pen  in  1  parity enable.
- ohel  in  1  parity select: 1 = odd, 0 = even.
- DONE  in  1  from bit counter; high when its count equals 11.
- DOIT  out  1  frame in progress; enables the bit counter.
- BTU  out  1  one-cycle bit-time-up pulse.
- TX  out  1  serial line output.
- TXRDY  out  1  ready for a new byte.

Behaviour:
- Interface: one clock; reset is synchronous and active-high; clock port is clk, reset port is reset.
- Reset values: TX=1, TXRDY=1, DOIT=0, BTU=0, shift register all 1s, bit-time counter 0, load_d1=0.
- Accept:
  - load & TXRDY latches out_port into ldata and asserts load_d1 on the next edge.
  - TXRDY falls on the same edge as the ldata capture.
- Frame build (cycle after accept, i.e. when load_d1=1):
  - shift[10:0] = {1, b9, b8, ldata[6:0], 0}.
  - eight=1, pen=1: b8 = ldata[7], b9 = parity.
  - eight=1, pen=0: b8 = ldata[7], b9 = 1.
  - eight=0, pen=1: b8 = parity, b9 = 1.
  - eight=0, pen=0: b8 = 1, b9 = 1.
  - parity = XOR of the data bits in use, inverted when ohel=1.
  - The same edge sets DOIT=1.
- Bit timer:
  - While DOIT=1, the counter increments each clk.
  - BTU = (count == divisor-1), combinational from the registered count.
  - The counter clears on BTU and whenever DOIT=0.
  - First BTU occurs exactly divisor clocks after DOIT rises.
- Shift: on BTU, shift <= {1, shift[10:1]}. TX = shift[0], registered, so the start bit appears one clock after DOIT rises.
- Completion: DONE=1 sampled at an edge gives DOIT<=0 and TXRDY<=1 on that edge. TX rests at 1 because the shift register is 1-filled.
- Each frame lasts 11 bit times, so DONE follows the 11th BTU.
- load while TXRDY=0: ignored, and ldata is unchanged.
- load on the same edge that DONE completes a frame: ignored, because TXRDY is still 0 at sampling. The CPU retries.
- baud_sel change mid-frame: takes effect on the next counter compare. Undefined timing, not a requirement to preserve.
- baud_sel 12..15: treated as index 11.
- reset mid-frame: immediate return to reset values; the partial frame is dropped.

Optional Feature:
- Macro: UART_TX_BREAK_EN.
- Defined:
  - Adds input port brk (1 bit).
  - While brk=1, TX is forced to 0 on the next edge, regardless of frame state. The frame timing continues underneath.
  - TX releases to its normal value one clock after brk falls.
- Undefined: no brk port; TX is driven only by the shift register.

Decomposition:
- Package uart_tx_pkg holds:
  - FRAME_BITS=11.
  - BAUD_DIV table at 100 MHz, indices 0-11: 333333, 83333, 41667, 20833, 10417, 5208, 2604, 1736, 868, 434, 217, 109.
  - Function frame_bits(ldata, eight, pen, ohel) returning the 11-bit frame.
- Sub-module bit_time_counter: inputs clk, reset, DOIT, div; output BTU.

Test Plan:
- Reset with DIV_OVERRIDE=4 -> TX=1, TXRDY=1, DOIT=0, BTU=0 held for 20 cycles.
- load with out_port=8'hA5, eight=1, pen=1, ohel=0 -> TX sequence 0,1,0,1,0,0,1,0,1,0,1, each bit 4 clocks (parity 0 since even count of ones); TXRDY=1 the edge after DONE.
- eight=0, pen=0, out_port=8'hFF -> data bits 1111111, then b8=1, b9=1; exactly 11 BTU pulses spaced 4 clocks.
- Second load while busy with out_port=8'h00 -> ignored; the first frame completes unchanged and no second frame starts.
- reset asserted at bit 5 -> next edge TX=1, DOIT=0, TXRDY=1; a following load of 8'h3C transmits a correct full frame.
- DIV_OVERRIDE=0, baud_sel=8 -> BTU period exactly 868 clocks; baud_sel=15 -> period 109.
